lut_neuron_loader: RTL and testbench
====================================

LUT_NEURON_LOADER -- requirements
Module: lut_neuron_loader

Interface
REQ-001 SHALL have parameter IN_BITS, default 6, meaning neuron input width, giving a table depth of 2**IN_BITS.
REQ-002 SHALL have parameter OUT_BITS, default 2, meaning the width of each table entry.
REQ-003 SHALL have parameter CFG_W, default 8, meaning config beat width; CFG_W multiple of OUT_BITS, CFG_W divides (2**IN_BITS)*OUT_BITS.
REQ-004 Ports, one per line, clock and reset first:
  clk  input  1  sole clock, rising edge.
  rst  input  1  asynchronous, active-high reset.
  cfg_valid  input  1  config beat valid.
  cfg_ready  output  1  loader accepts config beat.
  cfg_data  input  CFG_W  packed entries, lowest entry in LSBs.
  cfg_last  input  1  final beat of table image.
  M0  input  IN_BITS  inference address.
  in_valid  input  1  M0 valid.
  in_ready  output  1  inference port accepts M0.
  M1  output  OUT_BITS  looked-up entry.
  out_valid  output  1  M1 valid.
  loaded  output  1  a complete table image is resident.
  cfg_err  output  1  sticky length error.

Function
REQ-005 SHALL hold the table in a (2**IN_BITS) x OUT_BITS register array; entry i is the value returned for M0 == i.
REQ-006 FSM states SHALL be EMPTY, LOAD and ACTIVE; the reset state SHALL be EMPTY.
REQ-007 EMPTY -> LOAD on the first accepted beat; LOAD -> ACTIVE on an accepted beat with cfg_last=1 and beat count = BEATS-1, where BEATS = (2**IN_BITS)*OUT_BITS/CFG_W (16 by default).
REQ-008 A beat is accepted iff cfg_valid && cfg_ready; cfg_ready SHALL be 1 in every state, so reload is allowed from ACTIVE (ACTIVE -> LOAD).
REQ-009 Beat k SHALL write entries k*(CFG_W/OUT_BITS) through k*(CFG_W/OUT_BITS)+CFG_W/OUT_BITS-1; the beat counter SHALL reset to 0 on entry to LOAD.
REQ-010 cfg_last on beat k < BEATS-1 SHALL set cfg_err, discard the image and go to EMPTY.
REQ-011 An accepted beat BEATS-1 without cfg_last SHALL set cfg_err, discard the image and go to EMPTY.
REQ-012 cfg_err SHALL clear only on reset or on a successful LOAD -> ACTIVE transition.
REQ-013 loaded SHALL be 1 only in ACTIVE.
REQ-014 in_ready SHALL be 1 only in ACTIVE.
REQ-015 An accepted M0 SHALL produce M1 = table[M0] with out_valid=1 exactly one cycle later, registered, with no backpressure.
REQ-016 When no M0 is accepted, out_valid SHALL be 0 and M1 SHALL hold its last value.
REQ-017 When a config beat and an inference are accepted in the same ACTIVE cycle, the inference SHALL read the pre-write table, and the FSM SHALL enter LOAD, dropping in_ready the next cycle.

Reset
REQ-018 rst SHALL asynchronously force: state EMPTY, beat counter 0, M1=0, out_valid=0, loaded=0, cfg_err=0, in_ready=0.
REQ-019 Table contents SHALL be cleared to 0 on reset; reset mid-LOAD SHALL leave loaded=0 until a full reload completes.

Configuration
REQ-020 Macro LUT_NEURON_LOADER_READBACK_EN, when defined, SHALL add ports rb_addr (input, IN_BITS) and rb_data (output, OUT_BITS); rb_data SHALL be table[rb_addr] registered, one cycle latency, valid in any state.
REQ-021 Without LUT_NEURON_LOADER_READBACK_EN, those ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-022 The FSM state enum and the BEATS derivation function SHALL live in the shared package lut_loader_pkg.
REQ-023 The table array and registered read SHALL be one sub-module, lut_table_ram (one write port of CFG_W bits, one or two read ports); FSM and counter SHALL stay in the top module.

Verification
REQ-024 Load 16 beats of 8'hE4 with cfg_last on beat 15 -> loaded=1 after beat 15; M0=6'd0..3 return 0,1,2,3 one cycle later, each with out_valid=1.
REQ-025 cfg_last on beat 7 -> cfg_err=1, loaded=0, in_ready=0; a full 16-beat reload then -> cfg_err=0, loaded=1.
REQ-026 In ACTIVE with table[5]=2'b11, drive in_valid with M0=5 and a new first beat in the same cycle -> M1=2'b11 next cycle; in_ready=0 the cycle after that.
REQ-027 Assert rst during beat 9 of LOAD -> all outputs 0 immediately; in_valid ignored until a complete reload.
REQ-028 Drive 17 beats with no cfg_last -> cfg_err=1 after beat 15; the 17th beat starts a new LOAD.
REQ-029 With LUT_NEURON_LOADER_READBACK_EN defined, after loading all entries = 2'b10 -> rb_data=2'b10 one cycle after any rb_addr; with the macro undefined, the build SHALL contain no rb_* ports.

Source files
------------

// File: rtl/lut_loader_pkg.sv
// lut_loader_pkg: shared definitions for the LUT neuron loader.
//   state_t    - loader FSM states (EMPTY, LOAD, ACTIVE)
//   calc_beats - number of config beats that make up one full table image
package lut_loader_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  // Beats per image: (2**in_bits) entries of out_bits each, cfg_w bits per beat.
  function automatic int unsigned calc_beats(input int unsigned in_bits,
                                             input int unsigned out_bits,
                                             input int unsigned cfg_w);
    return ((32'd1 << in_bits) * out_bits) / cfg_w;
  endfunction

endpackage

// File: rtl/lut_neuron_loader_table.sv
// lut_table_ram: (2**IN_BITS) x OUT_BITS register table with one CFG_W-bit
// write port (one beat = CFG_W/OUT_BITS consecutive entries) and a registered
// read port. Optional readback port under LUT_NEURON_LOADER_READBACK_EN.
// Ports:
//   clk, rst          clock, async active-high reset (clears table and reads)
//   wr_en, wr_beat    write enable and beat index selecting the entry group
//   wr_data           packed entries, lowest entry in LSBs
//   rd_en, rd_addr    registered read request; rd_data holds when rd_en=0
//   rd_data           table[rd_addr] one cycle after rd_en
//   rb_addr, rb_data  (macro only) free-running registered readback
module lut_table_ram #(
  parameter int unsigned IN_BITS  = 6,
  parameter int unsigned OUT_BITS = 2,
  parameter int unsigned CFG_W    = 8,
  parameter int unsigned BEAT_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [BEAT_W-1:0]   wr_beat,
  input  logic [CFG_W-1:0]    wr_data,
  input  logic                rd_en,
  input  logic [IN_BITS-1:0]  rd_addr,
  output logic [OUT_BITS-1:0] rd_data
`ifdef LUT_NEURON_LOADER_READBACK_EN
  ,
  input  logic [IN_BITS-1:0]  rb_addr,
  output logic [OUT_BITS-1:0] rb_data
`endif
);

  localparam int unsigned DEPTH = 2 ** IN_BITS;
  localparam int unsigned EPB   = CFG_W / OUT_BITS;

  logic [OUT_BITS-1:0] tbl [DEPTH];

  // Entry i belongs to beat i/EPB, at slot i%EPB within that beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if ((i / EPB) == 32'(wr_beat))
          tbl[i] <= wr_data[(i % EPB) * OUT_BITS +: OUT_BITS];
      end
    end
  end

  // Nonblocking read sees the table as it was before a same-edge write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= tbl[rd_addr];
  end

`ifdef LUT_NEURON_LOADER_READBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rb_data <= '0;
    else     rb_data <= tbl[rb_addr];
  end
`endif

endmodule

// File: rtl/lut_neuron_loader.sv
// lut_neuron_loader: streams a LUT image in CFG_W-bit beats into a table and
// serves single-cycle-latency lookups once a complete image is resident.
// Optional macro LUT_NEURON_LOADER_READBACK_EN adds rb_addr/rb_data.
// Ports:
//   clk, rst                     clock, async active-high reset
//   cfg_valid/cfg_ready          config beat handshake (cfg_ready always 1)
//   cfg_data, cfg_last           packed entries / final beat marker
//   M0, in_valid, in_ready       inference address handshake (ACTIVE only)
//   M1, out_valid                looked-up entry, one cycle after accept
//   loaded                       complete image resident (ACTIVE)
//   cfg_err                      sticky image length error
module lut_neuron_loader
  import lut_loader_pkg::*;
#(
  parameter int unsigned IN_BITS  = 6,
  parameter int unsigned OUT_BITS = 2,
  parameter int unsigned CFG_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CFG_W-1:0]    cfg_data,
  input  logic                cfg_last,
  input  logic [IN_BITS-1:0]  M0,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUT_BITS-1:0] M1,
  output logic                out_valid,
  output logic                loaded,
  output logic                cfg_err
`ifdef LUT_NEURON_LOADER_READBACK_EN
  ,
  input  logic [IN_BITS-1:0]  rb_addr,
  output logic [OUT_BITS-1:0] rb_data
`endif
);

  localparam int unsigned BEATS  = calc_beats(IN_BITS, OUT_BITS, CFG_W);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_t            state, state_n;
  logic [BEAT_W-1:0] cnt, cnt_n;
  logic              err_n;
  logic [BEAT_W-1:0] beat_idx;
  logic              beat_acc;
  logic              infer_acc;

  assign cfg_ready = 1'b1;
  assign in_ready  = (state == ACTIVE);
  assign loaded    = (state == ACTIVE);
  assign beat_acc  = cfg_valid && cfg_ready;
  assign infer_acc = in_valid && in_ready;

  // A beat arriving outside LOAD is beat 0 of a fresh image.
  assign beat_idx  = (state == LOAD) ? cnt : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      cnt     <= '0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      cfg_err <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = cfg_err;
    if (beat_acc) begin
      if (beat_idx == LAST_BEAT) begin
        cnt_n = '0;
        if (cfg_last) begin
          state_n = ACTIVE;
          err_n   = 1'b0;
        end else begin
          state_n = EMPTY;
          err_n   = 1'b1;
        end
      end else if (cfg_last) begin
        state_n = EMPTY;
        cnt_n   = '0;
        err_n   = 1'b1;
      end else begin
        state_n = LOAD;
        cnt_n   = beat_idx + BEAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= infer_acc;
  end

  lut_table_ram #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS),
    .CFG_W    (CFG_W),
    .BEAT_W   (BEAT_W)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (beat_acc),
    .wr_beat (beat_idx),
    .wr_data (cfg_data),
    .rd_en   (infer_acc),
    .rd_addr (M0),
    .rd_data (M1)
`ifdef LUT_NEURON_LOADER_READBACK_EN
    ,
    .rb_addr (rb_addr),
    .rb_data (rb_data)
`endif
  );

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Scoreboard bench for lut_neuron_loader (default build, readback macro off).
module tb_lut_neuron_loader;

  localparam int IN_BITS  = 6;
  localparam int OUT_BITS = 2;
  localparam int CFG_W    = 8;
  localparam int DEPTH    = 64;
  localparam int EPB      = 4;
  localparam int BEATS    = 16;

  logic                clk;
  logic                rst;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CFG_W-1:0]    cfg_data;
  logic                cfg_last;
  logic [IN_BITS-1:0]  M0;
  logic                in_valid;
  logic                in_ready;
  logic [OUT_BITS-1:0] M1;
  logic                out_valid;
  logic                loaded;
  logic                cfg_err;

  lut_neuron_loader #(
    .IN_BITS  (IN_BITS),
    .OUT_BITS (OUT_BITS),
    .CFG_W    (CFG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .M0        (M0),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .M1        (M1),
    .out_valid (out_valid),
    .loaded    (loaded),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: resident table, image being collected, and flags.
  logic [1:0] m_tbl [DEPTH];
  logic [7:0] img   [$];
  bit         m_active;
  bit         m_err;
  logic [1:0] exp_q [$];
  logic [1:0] hold;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = 2'd0;
    img.delete();
    m_active = 0;
    m_err    = 0;
    exp_q.delete();
    hold     = 2'd0;
  endfunction

  // An image is good only if it is exactly BEATS beats with last on the final one.
  function automatic void model_beat(input logic [7:0] d, input bit last);
    logic [7:0] b;
    img.push_back(d);
    m_active = 0;
    if (last && img.size() == BEATS) begin
      for (int k = 0; k < BEATS; k++) begin
        b = img[k];
        for (int j = 0; j < EPB; j++)
          m_tbl[k * EPB + j] = 2'((int'(b) >> (OUT_BITS * j)) & 3);
      end
      m_active = 1;
      m_err    = 0;
      img.delete();
    end else if (last || img.size() == BEATS) begin
      m_err = 1;
      img.delete();
    end
  endfunction

  task automatic check_status();
    check("in_ready", int'(in_ready), int'(m_active));
    check("loaded",   int'(loaded),   int'(m_active));
    check("cfg_err",  int'(cfg_err),  int'(m_err));
    check("cfg_ready", int'(cfg_ready), 1);
  endtask

  // Called at posedge+1: check status, drive one cycle, advance model.
  task automatic step(input bit cv, input logic [7:0] cd, input bit cl,
                      input bit iv, input logic [5:0] m0);
    check_status();
    cfg_valid = cv;
    cfg_data  = cd;
    cfg_last  = cl;
    in_valid  = iv;
    M0        = m0;
    if (iv && m_active) exp_q.push_back(m_tbl[m0]);
    if (cv) model_beat(cd, cl);
    @(posedge clk);
    #1;
    cfg_valid = 0;
    cfg_last  = 0;
    in_valid  = 0;
  endtask

  task automatic do_reset();
    #2;
    rst = 1;
    #1;
    check("rst_loaded",    int'(loaded),    0);
    check("rst_in_ready",  int'(in_ready),  0);
    check("rst_cfg_err",   int'(cfg_err),   0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_M1",        int'(M1),        0);
    model_reset();
    @(posedge clk);
    #1;
    rst       = 0;
    cfg_valid = 0;
    cfg_last  = 0;
    in_valid  = 0;
  endtask

  // Full image; random in_valid on gap cycles and beats.
  task automatic load_full(input bit rnd, input logic [7:0] fill, input bit gaps);
    for (int k = 0; k < BEATS; k++) begin
      if (gaps && $urandom_range(0, 2) == 0)
        step(0, 8'h00, 0, 1'($urandom), 6'($urandom));
      step(1, rnd ? 8'($urandom) : fill, k == BEATS - 1, 1'($urandom), 6'($urandom));
    end
  endtask

  task automatic infer_burst(input int n);
    for (int i = 0; i < n; i++)
      step(0, 8'h00, 0, 1'($urandom_range(0, 3) != 0), 6'($urandom));
  endtask

  // Monitor: pop on every out_valid; otherwise M1 must hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_valid: got 1 expected 0 (no pending lookup) at %0t", $time);
        end else begin
          hold = exp_q.pop_front();
          check("M1", int'(M1), int'(hold));
        end
      end else begin
        check("M1_hold", int'(M1), int'(hold));
      end
    end
  end

  initial begin
    rst       = 1;
    cfg_valid = 0;
    cfg_data  = '0;
    cfg_last  = 0;
    in_valid  = 0;
    M0        = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Inference ignored while empty.
    infer_burst(4);

    // 16 beats of E4: entries cycle 0,1,2,3.
    load_full(0, 8'hE4, 0);
    for (int a = 0; a < 4; a++) step(0, 8'h00, 0, 1, 6'(a));
    step(0, 8'h00, 0, 0, 6'd0);

    // Early cfg_last on beat 7, then a good reload.
    for (int k = 0; k < 8; k++) step(1, 8'($urandom), k == 7, 0, 6'd0);
    infer_burst(3);
    load_full(1, 8'h00, 1);
    infer_burst(12);

    // Same-cycle beat and lookup in ACTIVE: table[5]=3 read pre-write.
    load_full(0, 8'hFC, 0);
    step(1, 8'h00, 0, 1, 6'd5);
    step(0, 8'h00, 0, 1, 6'd5);
    for (int k = 1; k < BEATS; k++) step(1, 8'($urandom), k == BEATS - 1, 0, 6'd0);
    step(1, 8'h1B, 0, 1, 6'd1);
    for (int k = 1; k < BEATS; k++) step(1, 8'($urandom), k == BEATS - 1, 0, 6'd0);
    infer_burst(8);

    // Reset during beat 9 of a load.
    for (int k = 0; k < 9; k++) step(1, 8'($urandom), 0, 0, 6'd0);
    cfg_valid = 1;
    cfg_data  = 8'hA5;
    in_valid  = 1;
    do_reset();
    infer_burst(4);
    load_full(1, 8'h00, 0);
    infer_burst(8);

    // 17 beats without cfg_last; the 17th opens a new load which is then completed.
    for (int k = 0; k < 17; k++) step(1, 8'($urandom), 0, 0, 6'd0);
    for (int k = 1; k < BEATS; k++) step(1, 8'($urandom), k == BEATS - 1, 0, 6'd0);
    infer_burst(8);

    // Random mix of good loads, bad loads, bursts and reload-under-traffic.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: load_full(1, 8'h00, 1);
        1: begin
          int stop;
          stop = $urandom_range(0, BEATS - 2);
          for (int k = 0; k <= stop; k++) step(1, 8'($urandom), k == stop, 0, 6'd0);
        end
        2: infer_burst($urandom_range(4, 20));
        default: begin
          step(1, 8'($urandom), 0, 1, 6'($urandom));
          for (int k = 1; k < BEATS; k++)
            step(1, 8'($urandom), k == BEATS - 1, 1'($urandom), 6'($urandom));
        end
      endcase
    end
    infer_burst(6);
    step(0, 8'h00, 0, 0, 6'd0);
    step(0, 8'h00, 0, 0, 6'd0);

    check("pending_lookups", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
